// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encodings and GF(2^8) / round-transform helpers
// used by the cipher core and its S-box.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef logic [1:0] state_t;
  localparam state_t IDLE       = 2'd0;
  localparam state_t ENC_RUN    = 2'd1;
  localparam state_t DEC_KEYEXP = 2'd2;
  localparam state_t DEC_RUN    = 2'd3;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a [4];
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      if (inv)
        b[i] = gf_mul(a[i], 8'd14) ^ gf_mul(a[(i+1)%4], 8'd11) ^
               gf_mul(a[(i+2)%4], 8'd13) ^ gf_mul(a[(i+3)%4], 8'd9);
      else
        b[i] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
    return o;
  endfunction

  // State byte n sits at row n%4, column n/4 and occupies s[127-8n -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*(inv ? (c+4-r)%4 : (c+r)%4)) -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inversion with the forward affine map,
// or the inverse affine map followed by inversion when inv=1.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] pre;
  logic [7:0] g;

  assign pre = inv ? inv_affine(a) : a;
  assign g   = gf_inv(pre);
  assign y   = inv ? g : affine(g);

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128 encrypt/decrypt core: one round per clock, round keys
// generated on the fly forwards (encrypt) or backwards from rk10 (decrypt).
module aes_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         function_in,
  input  logic [0:127] data,
  input  logic [0:127] key,
  output logic [0:127] cipher,
  output logic         busy,
  output logic         done
);

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] din, kin;
  logic [127:0] sb, sr, nk, pk, enc_out, dec_tmp, dec_out;
  logic [31:0]  w0, w1, w2, w3, ks_word, rot, sw, t;
  logic         dec_run;

  assign din     = data;
  assign kin     = key;
  assign busy    = (state != IDLE);
  assign dec_run = (state == DEC_RUN);

  // Key schedule: forward step from w3, backward step from recovered w3^w2.
  assign {w0, w1, w2, w3} = rk;
  assign ks_word = dec_run ? (w3 ^ w2) : w3;
  assign rot     = {ks_word[23:0], ks_word[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_ks_sbox
    aes_sbox u_sbox (.inv(1'b0), .a(rot[31-8*i -: 8]), .y(sw[31-8*i -: 8]));
  end

  assign t  = sw ^ {rcon(cnt), 24'h0};
  assign nk = {w0 ^ t, w0 ^ t ^ w1, w0 ^ t ^ w1 ^ w2, w0 ^ t ^ w1 ^ w2 ^ w3};
  assign pk = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  // Byte substitution commutes with row shifting, so both directions share one path.
  for (genvar i = 0; i < 16; i++) begin : g_dp_sbox
    aes_sbox u_sbox (.inv(dec_run), .a(st[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
  end

  assign sr      = shift_rows(sb, dec_run);
  assign enc_out = ((cnt == NR) ? sr : mix_state(sr, 1'b0)) ^ nk;
  assign dec_tmp = sr ^ pk;
  assign dec_out = (cnt == 4'd1) ? dec_tmp : mix_state(dec_tmp, 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      cipher <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt   <= 4'd1;
          state <= function_in ? ENC_RUN : DEC_KEYEXP;
        end
        ENC_RUN: if (cnt == NR) begin
          state  <= IDLE;
          done   <= 1'b1;
          cipher <= enc_out;
        end else begin
          cnt <= cnt + 4'd1;
        end
        DEC_KEYEXP: if (cnt == NR) begin
          state <= DEC_RUN;
          cnt   <= NR + 4'd1;
        end else begin
          cnt <= cnt + 4'd1;
        end
        DEC_RUN: if (cnt == 4'd1) begin
          state  <= IDLE;
          done   <= 1'b1;
          cipher <= dec_out;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: block and round-key registers are not reset; they are always
  // loaded on an accepted start before anything reads them.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        st <= function_in ? (din ^ kin) : din;
        rk <= kin;
      end
      ENC_RUN: begin
        st <= enc_out;
        rk <= nk;
      end
      DEC_KEYEXP: rk <= nk;
      DEC_RUN: if (cnt == NR + 4'd1) begin
        st <= st ^ rk;
      end else begin
        st <= dec_out;
        rk <= pk;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_cipher.sv
// Scoreboard bench for aes_cipher: directed FIPS-197 vectors plus random
// encrypt/decrypt traffic checked against a textbook AES reference model.
module tb_aes_cipher;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         function_in;
  logic [0:127] data;
  logic [0:127] key;
  logic [0:127] cipher;
  logic         busy;
  logic         done;

  aes_cipher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .function_in(function_in),
    .data(data), .key(key), .cipher(cipher), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] exp;
    int           due;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int x = a;
    int y = b;
    int p = 0;
    while (y != 0) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
      y = y >> 1;
    end
    return p[7:0];
  endfunction

  // S-box tables built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = i[7:0];
  endtask

  function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] d, input bit enc);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = d[127-8*n -: 8];
    if (enc) begin
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[n/4][31-8*(n%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
        for (int n = 0; n < 16; n++) s[n] = sbox_t[s[n]];
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
        s = t;
        if (r < 10)
          for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[4*c+i];
            for (int i = 0; i < 4; i++)
              s[4*c+i] = gmul(8'd2, a[i]) ^ gmul(8'd3, a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
          end
        for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r+n/4][31-8*(n%4) -: 8];
      end
    end else begin
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[40+n/4][31-8*(n%4) -: 8];
      for (int r = 9; r >= 0; r--) begin
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) t[rr+4*((c+rr)%4)] = s[rr+4*c];
        s = t;
        for (int n = 0; n < 16; n++) s[n] = isbox_t[s[n]];
        for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r+n/4][31-8*(n%4) -: 8];
        if (r > 0)
          for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[4*c+i];
            for (int i = 0; i < 4; i++)
              s[4*c+i] = gmul(8'd14, a[i]) ^ gmul(8'd11, a[(i+1)%4]) ^
                         gmul(8'd13, a[(i+2)%4]) ^ gmul(8'd9, a[(i+3)%4]);
          end
      end
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 128'(done), 128'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", cipher, e.exp);
        check("done_latency", 128'(cyc), 128'(e.due));
        check("busy_with_done", 128'(busy), 128'(0));
      end
    end
  end

  // Called at a falling edge; start is sampled on the following rising edge.
  task automatic issue(input logic fn, input logic [127:0] d, input logic [127:0] k,
                       input logic [127:0] exp, input bit push);
    exp_t e;
    start       = 1'b1;
    function_in = fn;
    data        = d;
    key         = k;
    if (push) begin
      e.exp = exp;
      e.due = cyc + 1 + (fn ? 10 : 21);
      sb_q.push_back(e);
    end
    @(negedge clk);
    start       = 1'b0;
    function_in = $urandom_range(0, 1);
    data        = {$urandom, $urandom, $urandom, $urandom};
    key         = {$urandom, $urandom, $urandom, $urandom};
    check("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 128'(0), 128'(1));
  endtask

  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] rk, rd;
    logic         fn;
    build_sbox();
    rst_n = 1'b0;
    start = 1'b0;
    function_in = 1'b0;
    data = '0;
    key  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_cipher", cipher, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, PB, KB, CB, 1'b1);
    wait_done();
    issue(1'b1, PC, KC, CC, 1'b1);
    wait_done();
    issue(1'b0, CC, KC, PC, 1'b1);
    wait_done();
    issue(1'b1, '0, '0, CZ, 1'b1);
    wait_done();
    issue(1'b0, CZ, '0, '0, 1'b1);
    wait_done();
    @(negedge clk);

    // A start raised mid-operation must not disturb the running block.
    issue(1'b1, PC, KC, CC, 1'b1);
    repeat (2) @(negedge clk);
    issue(1'b0, PB, KB, '0, 1'b0);
    wait_done();
    repeat (15) @(negedge clk);

    // Abort an encrypt with reset sampled on the fifth edge after start.
    issue(1'b1, PB, KB, '0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_cipher", cipher, 128'(0));
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_cipher_hold", cipher, 128'(0));

    issue(1'b1, PB, KB, CB, 1'b1);
    wait_done();
    for (int i = 0; i < 10; i++) begin
      fn = $urandom_range(0, 1);
      rk = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      issue(fn, rd, rk, ref_cipher(rk, rd, fn), 1'b1);
      wait_done();
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_cipher.md
# aes_cipher

Iterative AES-128 block cipher core (FIPS-197) performing either encryption or decryption of one 128-bit block under a 128-bit key, selected per operation. It sits between a host/stimulus front end that supplies key and plaintext/ciphertext and a consumer that reads the result register. One AES round is computed per clock, and round keys are generated on the fly.

## Interface
- No parameters. Key size is fixed at 128 bits and the round count at 10.
- `clk  in  1`  sole clock; all state updates on the rising edge.
- `rst_n  in  1`  reset, synchronous, active-low.
- `start  in  1`  one-cycle request; sampled only while `busy`=0.
- `function_in  in  1`  mode: 1 = encrypt, 0 = decrypt. Sampled with `start`.
- `data  in  128 [0:127]`  input block (plaintext or ciphertext). Index 0 is the MSB of FIPS byte 0. Sampled with `start`.
- `key  in  128 [0:127]`  cipher key, same byte order. Sampled with `start`.
- `cipher  out  128 [0:127]`  result register (ciphertext or recovered plaintext). Holds until the next completion.
- `busy  out  1`  high from the cycle after an accepted `start` through the final round.
- `done  out  1`  one-cycle pulse; `cipher` is valid in the same cycle.

## Operation
- Byte mapping: state byte n = bits [8n:8n+7]. Bytes fill the state column-major, as in FIPS-197.
- Encrypt:
  - Round 0 is AddRoundKey(key).
  - Rounds 1–9 are SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10 omits MixColumns.
- Decrypt:
  - First run the forward key schedule for 10 steps to obtain round key 10 (no state processing during these steps).
  - Then AddRoundKey(rk10).
  - Rounds 9..1 are InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  - The final round is InvShiftRows, InvSubBytes, AddRoundKey(rk0).
  - Round keys are regenerated backwards: w[i-4] = w[i] ^ f(w[i-1]), using the Rcon sequence in reverse.
- Key schedule:
  - Standard RotWord, SubWord and Rcon (01,02,04,08,10,20,40,80,1b,36).
  - The current round key is held in one 128-bit register; no 11-entry key store.
- States:
  - IDLE → (start) → ENC_RUN or DEC_KEYEXP.
  - DEC_KEYEXP → DEC_RUN after 10 cycles.
  - ENC_RUN and DEC_RUN → IDLE after the last round, pulsing `done`.
- `start` while `busy`=1 is ignored.
- `function_in`, `data` and `key` are don't-care except in the `start` cycle.
- `cipher` is written only at completion. `done` and `busy` are never high in the same cycle.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - `cipher`=0, `done`=0, `busy`=0, state IDLE.
  - An in-flight operation is aborted with no `done` and `cipher` unchanged from zero.
- Encrypt:
  - Edge E0 (start sampled): load state = data^key.
  - Edges E1..E10: rounds 1..10.
  - `cipher` loaded and `done`=1 after E10, i.e. 10 cycles after the `start` edge.
  - `busy` is high after E0 through E9.
- Decrypt:
  - E0: capture inputs.
  - E1..E10: key expansion.
  - E11: state = data^rk10.
  - E12..E21: inverse rounds.
  - `done` after E21, i.e. 21 cycles.
- Back-to-back: `start` may be asserted in the `done` cycle and is accepted, because `busy`=0.
- Throughput is one block per 11 (encrypt) or 22 (decrypt) cycles with back-to-back starts.

## Structure
- Shared package `aes_pkg`:
  - Rcon constants.
  - Round-count constant (10).
  - State-enum typedef.
  - Functions xtime, MixColumns and InvMixColumns column helpers.
- Sub-module `aes_sbox`:
  - Combinational, one byte in/out, with an `inv` select.
  - Computes GF(2^8) inversion (poly 0x11b) plus the forward affine map or its inverse.
  - Instantiated 16× for the datapath and 4× for the key schedule. Table-based implementation is also acceptable.
- Top `aes_cipher` holds:
  - FSM, round counter (4 bits), state register, round-key register, output register.

## Test plan
- Encrypt, FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 → cipher 3925841d02dc09fbdc118597196a0b32, `done` exactly 10 cycles after `start`.
- Encrypt, FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt, C.1: function_in=0, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a → 00112233445566778899aabbccddeeff, `done` 21 cycles after `start`.
- All-zero key and data, encrypt → 66e94bd4ef8a2c3b884cfa59ca342b2e. Then decrypt that back → all zeros, with `start` issued in the `done` cycle.
- `start` re-asserted with different data while busy → ignored; the result matches the first request.
- rst_n low at cycle 5 of an encrypt → `busy`=0, `done` never pulses, `cipher`=0. A fresh encrypt afterwards gives the correct result.
